// File: rtl/uart_tx_rx.sv
// uart_tx_rx: full-duplex 8N1 UART (1 start, 8 data LSB first, 1 stop, no parity).
// The TX and RX engines are independent and share one clock and a synchronous
// active-low reset. Each engine's FSM state is exported on a dbg_*_state port.
// Optional build macro UART_FRAME_CHECK_EN adds o_RX_Frame_Err. When it is set,
// a low stop-bit sample pulses o_RX_Frame_Err instead of o_RX_DV.
//
// Handshake: i_TX_DV is a one-cycle strobe. It is accepted only while the TX
// FSM is IDLE. A strobe that arrives at any other time is dropped, and nothing
// is queued. o_TX_Done and o_RX_DV are one-cycle pulses. o_RX_Byte is held
// until the next o_RX_DV.
module uart_tx_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
`ifdef UART_FRAME_CHECK_EN
  output logic       o_RX_Frame_Err,
`endif
  output logic [2:0] dbg_tx_state,
  output logic [2:0] dbg_rx_state
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_t;

  // ---------------------------------------------------------------- TX engine
  state_t          tx_state, tx_state_n;
  logic [CW-1:0]   tx_cnt, tx_cnt_n;
  logic [2:0]      tx_idx, tx_idx_n;
  logic [7:0]      tx_data, tx_data_n;

  // TX state and datapath registers
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_data  <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_data  <= tx_data_n;
    end
  end

  // TX next-state logic and outputs. The outputs decode the registered state,
  // so the line is low in the first cycle after an accepted strobe.
  always_comb begin
    tx_state_n  = tx_state;
    tx_cnt_n    = tx_cnt;
    tx_idx_n    = tx_idx;
    tx_data_n   = tx_data;
    o_TX_Serial = 1'b1;
    o_TX_Active = 1'b0;
    o_TX_Done   = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_n = '0;
        tx_idx_n = '0;
        if (i_TX_DV) begin
          tx_data_n  = i_TX_Byte;
          tx_state_n = S_START;
        end
      end
      S_START: begin
        o_TX_Serial = 1'b0;
        o_TX_Active = 1'b1;
        if (tx_cnt == LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = S_DATA;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      S_DATA: begin
        o_TX_Serial = tx_data[tx_idx];
        o_TX_Active = 1'b1;
        if (tx_cnt == LAST) begin
          tx_cnt_n = '0;
          if (tx_idx == 3'd7) begin
            tx_idx_n   = '0;
            tx_state_n = S_STOP;
          end else begin
            tx_idx_n = tx_idx + 3'd1;
          end
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      S_STOP: begin
        o_TX_Active = 1'b1;
        if (tx_cnt == LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = S_CLEANUP;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      S_CLEANUP: begin
        // The done pulse falls in the cycle right after the stop bit's last count.
        o_TX_Done  = 1'b1;
        tx_state_n = S_IDLE;
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX engine
  logic            rx_meta, rx_sync;
  state_t          rx_state, rx_state_n;
  logic [CW-1:0]   rx_cnt, rx_cnt_n;
  logic [2:0]      rx_idx, rx_idx_n;
  logic [7:0]      rx_shift, rx_shift_n;
  logic [7:0]      rx_byte_n;
  logic            rx_dv_n;
`ifdef UART_FRAME_CHECK_EN
  logic            rx_ferr_n;
`endif

  // Two-flop synchronizer for the asynchronous serial input. It resets to the
  // idle level.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_sync <= rx_meta;
    end
  end

  // RX state and datapath registers
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      o_RX_Byte <= '0;
      o_RX_DV   <= 1'b0;
`ifdef UART_FRAME_CHECK_EN
      o_RX_Frame_Err <= 1'b0;
`endif
    end else begin
      rx_state  <= rx_state_n;
      rx_cnt    <= rx_cnt_n;
      rx_idx    <= rx_idx_n;
      rx_shift  <= rx_shift_n;
      o_RX_Byte <= rx_byte_n;
      o_RX_DV   <= rx_dv_n;
`ifdef UART_FRAME_CHECK_EN
      o_RX_Frame_Err <= rx_ferr_n;
`endif
    end
  end

  // RX next-state logic. Bits are assembled in a shadow register, so
  // o_RX_Byte changes only together with o_RX_DV.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_byte_n  = o_RX_Byte;
    rx_dv_n    = 1'b0;
`ifdef UART_FRAME_CHECK_EN
    rx_ferr_n  = 1'b0;
`endif
    case (rx_state)
      S_IDLE: begin
        rx_cnt_n = '0;
        rx_idx_n = '0;
        if (!rx_sync) rx_state_n = S_START;
      end
      S_START: begin
        if (rx_cnt == MID) begin
          rx_cnt_n   = '0;
          // A line that has gone high again by mid-start is treated as a glitch.
          rx_state_n = rx_sync ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n           = '0;
          rx_shift_n[rx_idx] = rx_sync;
          if (rx_idx == 3'd7) begin
            rx_idx_n   = '0;
            rx_state_n = S_STOP;
          end else begin
            rx_idx_n = rx_idx + 3'd1;
          end
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = S_CLEANUP;
`ifdef UART_FRAME_CHECK_EN
          if (rx_sync) begin
            rx_dv_n   = 1'b1;
            rx_byte_n = rx_shift;
          end else begin
            rx_ferr_n = 1'b1;
          end
`else
          rx_dv_n   = 1'b1;
          rx_byte_n = rx_shift;
`endif
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      S_CLEANUP: rx_state_n = S_IDLE;
      default:   rx_state_n = S_IDLE;
    endcase
  end

  assign dbg_tx_state = tx_state;
  assign dbg_rx_state = rx_state;

endmodule

// File: tb/tb_uart_tx_rx.sv
// Testbench for uart_tx_rx: TX looped back to RX, with a bench override
// that drives the RX pin directly for glitch and stop-bit corner cases.
module tb_uart_tx_rx;

  localparam int C = 217;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active, tx_serial, tx_done;
  logic       rx_serial;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic [2:0] dbg_tx_state, dbg_rx_state;
  logic       rx_sel;
  logic       bench_rx;
`ifdef UART_FRAME_CHECK_EN
  logic       frame_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int dv_count = 0;
  int ferr_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rx = 8'h00;

  // ---------------------------------------------------------- clock / reset
  always #20 clk = ~clk;

  assign rx_serial = rx_sel ? bench_rx : (tx_active ? tx_serial : 1'b1);

  uart_tx_rx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock     (clk),
    .i_Rst_L     (rst_l),
    .i_TX_DV     (tx_dv),
    .i_TX_Byte   (tx_byte),
    .o_TX_Active (tx_active),
    .o_TX_Serial (tx_serial),
    .o_TX_Done   (tx_done),
    .i_RX_Serial (rx_serial),
    .o_RX_DV     (rx_dv),
    .o_RX_Byte   (rx_byte),
`ifdef UART_FRAME_CHECK_EN
    .o_RX_Frame_Err (frame_err),
`endif
    .dbg_tx_state(dbg_tx_state),
    .dbg_rx_state(dbg_rx_state)
  );

  initial begin
    #(40 * 95000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------- checking
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected TX line level k clocks after the strobe: frame is start, 8 data LSB first, stop.
  function automatic logic exp_level(input logic [7:0] b, input int k);
    int idx;
    idx = k / C;
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return b[3'(idx - 1)];
    else return 1'b1;
  endfunction

  // Scoreboard: each o_RX_DV pops one expected byte.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rx_dv) begin
      dv_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got o_RX_DV with byte 0x%0h, expected no pulse", rx_byte);
      end else begin
        e = exp_q.pop_front();
        check("rx_byte", int'(rx_byte), int'(e));
        last_rx = e;
      end
    end
`ifdef UART_FRAME_CHECK_EN
    if (frame_err) ferr_count++;
`endif
  end

  // ---------------------------------------------------------------- drivers
  task automatic do_reset();
    rst_l    = 1'b0;
    tx_dv    = 1'b0;
    tx_byte  = 8'h00;
    rx_sel   = 1'b0;
    bench_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_l   = 1'b1;
    last_rx = 8'h00;
  endtask

  // Strobe one byte and check the full TX waveform against the frame model.
  // inject_k >= 0 re-pulses i_TX_DV with 8'hAA mid-frame. abort_k >= 0 pulses reset.
  task automatic tx_frame(input logic [7:0] b, input int inject_k, input int abort_k);
    int errs;
    errs = 0;
    @(negedge clk);
    tx_dv   = 1'b1;
    tx_byte = b;
    @(negedge clk);
    tx_dv   = 1'b0;
    tx_byte = ~b;
    for (int k = 0; k < 10 * C; k++) begin
      if (tx_serial !== exp_level(b, k) || tx_active !== 1'b1 || tx_done !== 1'b0) errs++;
      if (k == abort_k) begin
        check("tx_wave_pre_abort", errs, 0);
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        last_rx = 8'h00;
        check("abort_tx_serial", int'(tx_serial), 1);
        check("abort_tx_active", int'(tx_active), 0);
        check("abort_rx_state", int'(dbg_rx_state), 0);
        return;
      end
      tx_dv = (k == inject_k);
      if (k == inject_k) tx_byte = 8'hAA;
      @(negedge clk);
    end
    check("tx_wave", errs, 0);
    check("tx_done_at_2170", int'(tx_done), 1);
    check("tx_active_end", int'(tx_active), 0);
    check("tx_serial_end", int'(tx_serial), 1);
    @(negedge clk);
  endtask

  // Drive a frame straight onto the RX pin with a chosen stop-bit level.
  task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
    rx_sel = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bench_rx = (i == 0) ? 1'b0 : (i == 9) ? stop : b[3'(i - 1)];
      repeat (C) @(negedge clk);
    end
    bench_rx = 1'b1;
    repeat (2 * C) @(negedge clk);
    rx_sel = 1'b0;
  endtask

  // ------------------------------------------------------------ test vectors
  typedef struct {
    logic [7:0] tx_byte;
    int         inject_k;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int dv0, act_cycles;
    logic [7:0] rb;

    vecs[0] = '{8'h3F, -1, 8'h3F};
    vecs[1] = '{8'h55, -1, 8'h55};
    vecs[2] = '{8'h00, -1, 8'h00};
    vecs[3] = '{8'hFF, -1, 8'hFF};
    vecs[4] = '{8'h81, -1, 8'h81};
    vecs[5] = '{8'h12, 3 * C + 5, 8'h12};

    do_reset();
    check("reset_tx_serial", int'(tx_serial), 1);
    check("reset_tx_active", int'(tx_active), 0);
    check("reset_tx_done", int'(tx_done), 0);
    check("reset_rx_dv", int'(rx_dv), 0);
    check("reset_rx_byte", int'(rx_byte), 0);
    check("reset_tx_state", int'(dbg_tx_state), 0);
    check("reset_rx_state", int'(dbg_rx_state), 0);

    // Table-driven loopback frames. The last entry carries an ignored mid-frame strobe.
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vecs[i].exp_rx);
      tx_frame(vecs[i].tx_byte, vecs[i].inject_k, -1);
    end
    act_cycles = 0;
    for (int i = 0; i < 3 * C; i++) begin
      if (tx_active) act_cycles++;
      @(negedge clk);
    end
    check("ignored_strobe_no_frame", act_cycles, 0);
    check("table_rx_drained", exp_q.size(), 0);

    // A 50-clock low glitch is rejected. RX returns to IDLE and then receives A5.
    dv0 = dv_count;
    rx_sel   = 1'b1;
    bench_rx = 1'b0;
    repeat (50) @(negedge clk);
    bench_rx = 1'b1;
    repeat (300) @(negedge clk);
    rx_sel = 1'b0;
    check("glitch_no_dv", dv_count - dv0, 0);
    check("glitch_rx_idle", int'(dbg_rx_state), 0);
    exp_q.push_back(8'hA5);
    tx_frame(8'hA5, -1, -1);

    // Random bytes with random gaps, which include back-to-back frames.
    for (int n = 0; n < 10; n++) begin
      rb = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 20)) @(negedge clk);
      exp_q.push_back(rb);
      tx_frame(rb, -1, -1);
    end
    for (int i = 0; i < 2 * C && exp_q.size() != 0; i++) @(negedge clk);
    check("random_rx_drained", exp_q.size(), 0);

    // Reset during data bit 3 aborts the frame. RX yields no byte.
    dv0 = dv_count;
    tx_frame(8'h5A, -1, 4 * C + 100);
    repeat (12 * C) @(negedge clk);
    check("abort_no_rx_dv", dv_count - dv0, 0);
    check("abort_rx_byte_cleared", int'(rx_byte), 0);

    // Establish a known last byte, then send C3 with a low stop bit.
    exp_q.push_back(8'h66);
    tx_frame(8'h66, -1, -1);
    repeat (C) @(negedge clk);
    dv0 = dv_count;
`ifdef UART_FRAME_CHECK_EN
    begin
      int fe0;
      fe0 = ferr_count;
      drive_rx_frame(8'hC3, 1'b0);
      check("frame_err_pulse", ferr_count - fe0, 1);
      check("frame_err_no_dv", dv_count - dv0, 0);
      check("frame_err_byte_held", int'(rx_byte), 8'h66);
    end
`else
    exp_q.push_back(8'hC3);
    drive_rx_frame(8'hC3, 1'b0);
    check("bad_stop_still_dv", dv_count - dv0, 1);
`endif

    for (int i = 0; i < 4 * C && exp_q.size() != 0; i++) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("rx_byte_held", int'(rx_byte), int'(last_rx));
    check("final_tx_idle", int'(dbg_tx_state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
